pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter ALUCTL_W, default 4, width of ALU control field; values below 4 are illegal.
REQ-002 Parameter EN_MULDIV, default 1, when 1 decodes RV32M (R-type, func7=0000001) as multi-cycle ops; when 0 such encodings are illegal.
REQ-003 Parameter MUL_LAT, default 3, EX-occupancy cycles of an M op, legal range 2..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 opcode  in  7  ID-stage instruction[6:0].
REQ-007 func3  in  3  ID-stage instruction[14:12].
REQ-008 func7  in  7  ID-stage instruction[31:25].
REQ-009 id_valid  in  1  ID holds a real instruction.
REQ-010 rs1_d, rs2_d  in  5 each  ID source register indices.
REQ-011 rd_e  in  5  EX destination register index.
REQ-012 branch_taken_e  in  1  EX branch/jump redirect.
REQ-013 mem_stall  in  1  data-memory not ready; freezes whole pipeline.
REQ-014 ImmSrc_d  out  2  combinational immediate select: 00 I, 01 S, 10 B, 11 J.
REQ-015 ALUCtl_e (ALUCTL_W), ALUSrc_e, Branch_e, Jump_e, MemWrite_e, ResultSrc_e (2), RegWrite_e, valid_e  out  EX-stage control bundle.
REQ-016 MemWrite_m, ResultSrc_m (2), RegWrite_m  out  MEM-stage bundle; ResultSrc_w (2), RegWrite_w  out  WB-stage bundle.
REQ-017 stall_fd  out  1  hold PC and IF/ID; flush_fd  out  1  clear IF/ID; illegal_d  out  1  undecodable valid ID instruction.

Function
REQ-018 Decode: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111; any other opcode with id_valid=1 SHALL assert illegal_d and be issued as a bubble.
REQ-019 ALUCtl: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 sltu, 10 mul, 11 mulh, 12 div, 13 rem; sub/sra only when func7[5]=1 and opcode[5]=1 (sub) or func3=101 (sra); lw/sw/jal add, branch sub; upper bits zero-extended to ALUCTL_W.
REQ-020 ResultSrc: 00 ALU, 01 memory (lw), 10 PC+4 (jal); RegWrite for R, I-ALU, lw, jal only.
REQ-021 Bubble SHALL be all-zero bundle with valid_e=0.
REQ-022 Each unfrozen edge: ID->EX, EX->MEM, MEM->WB; latency opcode to WB bundle 3 cycles.
REQ-023 Load-use: EX is lw with RegWrite_e=1, rd_e!=0, and rd_e equals rs1_d or rs2_d -> stall_fd=1, bubble into EX, MEM/WB advance.
REQ-024 branch_taken_e=1 -> flush_fd=1, bubble into EX; overrides load-use (stall_fd=0 that cycle).
REQ-025 FSM RUN/MBUSY: M op entering EX moves to MBUSY with counter=MUL_LAT-1; in MBUSY EX holds, stall_fd=1, bubble into MEM, counter decrements; at counter=0 returns to RUN and EX advances next edge.
REQ-026 mem_stall=1 freezes all stage registers, FSM and counter, asserts stall_fd; has priority over all other events except rst.
REQ-027 Priority: rst > mem_stall > MBUSY > branch_taken_e > load-use > normal.

Reset
REQ-028 rst=1 SHALL immediately clear all stage registers to bubble, FSM to RUN, counter to 0, stall_fd=0, flush_fd=0, including mid-MBUSY.
REQ-029 First edge after rst deassertion SHALL load ID normally.

Verification
REQ-030 add x3,x1,x2 then idle -> ALUCtl_e=0, RegWrite_e=1 after edge 1; RegWrite_w=1, ResultSrc_w=00 after edge 3.
REQ-031 lw x5 followed by add x6,x5,x1 -> stall_fd=1 one cycle, valid_e=0 one cycle, add reaches EX one cycle late.
REQ-032 mul with MUL_LAT=3 -> stall_fd=1 for 3 cycles, ALUCtl_e=10 held 3 cycles, MEM bubbles inserted, then resumes.
REQ-033 branch_taken_e=1 coincident with load-use -> flush_fd=1, stall_fd=0, valid_e=0 next cycle.
REQ-034 opcode 1111111 with id_valid=1 -> illegal_d=1, bubble in EX; rst asserted during MBUSY -> all outputs 0 asynchronously.
REQ-035 mem_stall=1 for 2 cycles mid-stream -> all bundles unchanged, stall_fd=1 both cycles.

Source files
------------

// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Control path for a 4-stage (ID/EX/MEM/WB) RV32I(+M) pipeline. Decodes the
//   ID instruction into a control bundle and moves it through EX, MEM and WB.
//   Load-use hazards, taken branches, multi-cycle M ops and data-memory
//   stalls are also handled here.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   opcode/func3/func7  ID instruction fields; id_valid marks a real instruction
//   rs1_d, rs2_d        ID source registers; rd_e EX destination register
//   branch_taken_e      EX redirect (flushes IF/ID)
//   mem_stall           data memory not ready (freezes the whole pipeline)
//   ImmSrc_d            immediate select for ID (00 I, 01 S, 10 B, 11 J)
//   *_e / *_m / *_w     EX / MEM / WB control bundles
//   stall_fd, flush_fd  hold / clear PC and IF/ID
//   illegal_d           valid ID instruction that cannot be decoded
module pipe_control_unit #(
  parameter int unsigned ALUCTL_W  = 4,
  parameter int unsigned EN_MULDIV = 1,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                id_valid,
  input  logic [4:0]          rs1_d,
  input  logic [4:0]          rs2_d,
  input  logic [4:0]          rd_e,
  input  logic                branch_taken_e,
  input  logic                mem_stall,
  output logic [1:0]          ImmSrc_d,
  output logic [ALUCTL_W-1:0] ALUCtl_e,
  output logic                ALUSrc_e,
  output logic                Branch_e,
  output logic                Jump_e,
  output logic                MemWrite_e,
  output logic [1:0]          ResultSrc_e,
  output logic                RegWrite_e,
  output logic                valid_e,
  output logic                MemWrite_m,
  output logic [1:0]          ResultSrc_m,
  output logic                RegWrite_m,
  output logic [1:0]          ResultSrc_w,
  output logic                RegWrite_w,
  output logic                stall_fd,
  output logic                flush_fd,
  output logic                illegal_d
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_MULH = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_REM  = 4'd13;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT - 1);

  typedef enum logic {RUN, MBUSY} state_e;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_write;
    logic [1:0] result_src;
    logic       reg_write;
    logic       valid;
  } ex_bundle_t;

  typedef struct packed {
    logic       mem_write;
    logic [1:0] result_src;
    logic       reg_write;
  } mem_bundle_t;

  typedef struct packed {
    logic [1:0] result_src;
    logic       reg_write;
  } wb_bundle_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  ex_bundle_t  ex_q, ex_d;
  mem_bundle_t mem_q, mem_d;
  wb_bundle_t  wb_q, wb_d;

  ex_bundle_t  dec;
  logic        dec_is_m;
  logic        dec_illegal;
  logic [1:0]  imm_src;
  logic [3:0]  base_alu;
  logic [3:0]  m_alu;
  logic        load_use;
  logic        stall;
  logic        flush;

  // ALU function from func3; sub only for register-register, sra for both.
  always_comb begin
    base_alu = ALU_ADD;
    case (func3)
      3'b000:  base_alu = (func7[5] && opcode[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = func7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  end

  // M-extension: mul / mulh(su/u) / div(u) / rem(u)
  always_comb begin
    m_alu = ALU_MUL;
    case (func3)
      3'b000:                 m_alu = ALU_MUL;
      3'b001, 3'b010, 3'b011: m_alu = ALU_MULH;
      3'b100, 3'b101:         m_alu = ALU_DIV;
      default:                m_alu = ALU_REM;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec_is_m    = 1'b0;
    dec_illegal = 1'b0;
    imm_src     = 2'b00;
    case (opcode)
      OP_LW: begin
        dec.alu_ctl    = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.reg_write  = 1'b1;
        imm_src        = 2'b00;
      end
      OP_SW: begin
        dec.alu_ctl   = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        imm_src       = 2'b01;
      end
      OP_R: begin
        if (func7 == F7_MULDIV) begin
          if (EN_MULDIV != 0) begin
            dec.alu_ctl   = m_alu;
            dec.reg_write = 1'b1;
            dec_is_m      = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec.alu_ctl   = base_alu;
          dec.reg_write = 1'b1;
        end
      end
      OP_I: begin
        dec.alu_ctl   = base_alu;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        imm_src       = 2'b00;
      end
      OP_BR: begin
        dec.alu_ctl = ALU_SUB;
        dec.branch  = 1'b1;
        imm_src     = 2'b10;
      end
      OP_JAL: begin
        dec.alu_ctl    = ALU_ADD;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
        imm_src        = 2'b11;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Idle slots and undecodable instructions become bubbles.
    if (!id_valid || dec_illegal) begin
      dec      = '0;
      dec_is_m = 1'b0;
    end else begin
      dec.valid = 1'b1;
    end
  end

  assign load_use = ex_q.valid && ex_q.reg_write && (ex_q.result_src == 2'b01) &&
                    (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // While MBUSY, the M op stays in EX for every busy cycle (counter
  // MUL_LAT-1 down to 0); the counter-0 edge only returns to RUN, so the op
  // leaves EX on the edge after that, together with the held ID instruction.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (mem_stall) begin
      stall = 1'b1;
    end else if (state_q == MBUSY) begin
      stall = 1'b1;
      mem_d = '0;
      wb_d  = {mem_q.result_src, mem_q.reg_write};
      if (cnt_q == 4'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      mem_d = {ex_q.mem_write, ex_q.result_src, ex_q.reg_write};
      wb_d  = {mem_q.result_src, mem_q.reg_write};
      if (branch_taken_e) begin
        flush = 1'b1;
        ex_d  = '0;
      end else if (load_use) begin
        stall = 1'b1;
        ex_d  = '0;
      end else begin
        ex_d = dec;
        if (dec_is_m) begin
          state_d = MBUSY;
          cnt_d   = CNT_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    ALUCtl_e      = '0;
    ALUCtl_e[3:0] = ex_q.alu_ctl;
  end

  assign ALUSrc_e    = ex_q.alu_src;
  assign Branch_e    = ex_q.branch;
  assign Jump_e      = ex_q.jump;
  assign MemWrite_e  = ex_q.mem_write;
  assign ResultSrc_e = ex_q.result_src;
  assign RegWrite_e  = ex_q.reg_write;
  assign valid_e     = ex_q.valid;
  assign MemWrite_m  = mem_q.mem_write;
  assign ResultSrc_m = mem_q.result_src;
  assign RegWrite_m  = mem_q.reg_write;
  assign ResultSrc_w = wb_q.result_src;
  assign RegWrite_w  = wb_q.reg_write;

  // Combinational outputs are forced low while reset is held.
  assign stall_fd  = stall & ~rst;
  assign flush_fd  = flush & ~rst;
  assign illegal_d = id_valid & dec_illegal & ~rst;
  assign ImmSrc_d  = rst ? 2'b00 : imm_src;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit
//   Decode table, directed hazard/stall/reset sequences and random traffic,
//   all compared against an instruction-level reference model of the
//   pipeline control behaviour.
module tb_pipe_control_unit;

  localparam int unsigned ALUCTL_W  = 4;
  localparam int unsigned EN_MULDIV = 1;
  localparam int unsigned MUL_LAT   = 3;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [6:0]          opcode = '0;
  logic [2:0]          func3 = '0;
  logic [6:0]          func7 = '0;
  logic                id_valid = 1'b0;
  logic [4:0]          rs1_d = '0;
  logic [4:0]          rs2_d = '0;
  logic [4:0]          rd_e = '0;
  logic                branch_taken_e = 1'b0;
  logic                mem_stall = 1'b0;
  logic [1:0]          ImmSrc_d;
  logic [ALUCTL_W-1:0] ALUCtl_e;
  logic                ALUSrc_e, Branch_e, Jump_e, MemWrite_e, RegWrite_e, valid_e;
  logic [1:0]          ResultSrc_e;
  logic                MemWrite_m, RegWrite_m, RegWrite_w;
  logic [1:0]          ResultSrc_m, ResultSrc_w;
  logic                stall_fd, flush_fd, illegal_d;

  pipe_control_unit #(.ALUCTL_W(ALUCTL_W), .EN_MULDIV(EN_MULDIV), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .id_valid(id_valid), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .branch_taken_e(branch_taken_e), .mem_stall(mem_stall), .ImmSrc_d(ImmSrc_d),
    .ALUCtl_e(ALUCtl_e), .ALUSrc_e(ALUSrc_e), .Branch_e(Branch_e), .Jump_e(Jump_e),
    .MemWrite_e(MemWrite_e), .ResultSrc_e(ResultSrc_e), .RegWrite_e(RegWrite_e),
    .valid_e(valid_e), .MemWrite_m(MemWrite_m), .ResultSrc_m(ResultSrc_m),
    .RegWrite_m(RegWrite_m), .ResultSrc_w(ResultSrc_w), .RegWrite_w(RegWrite_w),
    .stall_fd(stall_fd), .flush_fd(flush_fd), .illegal_d(illegal_d)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one record per stage, plus remaining M-op busy cycles.
  typedef struct packed {
    logic [3:0] alu;
    logic       src;
    logic       br;
    logic       jmp;
    logic       mw;
    logic [1:0] rs;
    logic       rw;
    logic       v;
    logic       m;
  } bnd_t;

  bnd_t m_ex, m_mem, m_wb;
  int   busy_left;

  // ALU code per func3 (nibble i = func3 i) for base ops and M ops.
  logic [31:0] base_tab = 32'h2374_9560;
  logic [31:0] mop_tab  = 32'hDDCC_BBBA;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;
    logic       src, br, jmp, mw;
    logic [1:0] rs;
    logic       rw;
    logic [1:0] imm;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic v,
                                     output bnd_t b, output logic ill, output logic [1:0] imm);
    b = '0; ill = 1'b0; imm = 2'b00;
    if (op == LW) begin
      b.src = 1'b1; b.rs = 2'b01; b.rw = 1'b1;
    end else if (op == SW) begin
      b.src = 1'b1; b.mw = 1'b1; imm = 2'b01;
    end else if (op == BR) begin
      b.alu = 4'd1; b.br = 1'b1; imm = 2'b10;
    end else if (op == JAL) begin
      b.jmp = 1'b1; b.rs = 2'b10; b.rw = 1'b1; imm = 2'b11;
    end else if (op == RR && f7 == 7'b0000001) begin
      if (EN_MULDIV != 0) begin
        b.alu = mop_tab[f3*4 +: 4]; b.rw = 1'b1; b.m = 1'b1;
      end else ill = 1'b1;
    end else if (op == RR || op == IA) begin
      b.alu = base_tab[f3*4 +: 4];
      if (f3 == 3'd0 && f7[5] && op == RR) b.alu = 4'd1;
      if (f3 == 3'd5 && f7[5]) b.alu = 4'd8;
      b.src = (op == IA);
      b.rw  = 1'b1;
    end else begin
      ill = 1'b1;
    end
    if (!v || ill) b = '0;
    else b.v = 1'b1;
    ill = ill & v;
  endfunction

  function automatic logic model_load_use();
    return m_ex.v && m_ex.rw && m_ex.rs == 2'b01 && rd_e != 5'd0 &&
           (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; busy_left = 0;
  endtask

  task automatic model_edge();
    bnd_t d; logic ill; logic [1:0] imm;
    ref_decode(opcode, func3, func7, id_valid, d, ill, imm);
    if (rst) model_reset();
    else if (mem_stall) begin
    end else if (busy_left > 0) begin
      m_wb = m_mem; m_mem = '0; busy_left--;
    end else begin
      m_wb = m_mem; m_mem = m_ex;
      if (branch_taken_e || model_load_use()) m_ex = '0;
      else begin
        m_ex = d;
        if (d.m) busy_left = int'(MUL_LAT);
      end
    end
  endtask

  function automatic logic [11:0] dut_ex();
    return {ALUCtl_e[3:0], ALUSrc_e, Branch_e, Jump_e, MemWrite_e, ResultSrc_e, RegWrite_e, valid_e};
  endfunction

  task automatic compare_all();
    bnd_t d; logic ill; logic [1:0] imm; logic es, ef;
    ref_decode(opcode, func3, func7, id_valid, d, ill, imm);
    es = !rst && (mem_stall || busy_left > 0 || (!branch_taken_e && model_load_use()));
    ef = !rst && !mem_stall && busy_left == 0 && branch_taken_e;
    chk("ex_bundle", 32'(dut_ex()),
        32'({m_ex.alu, m_ex.src, m_ex.br, m_ex.jmp, m_ex.mw, m_ex.rs, m_ex.rw, m_ex.v}));
    chk("mem_bundle", 32'({MemWrite_m, ResultSrc_m, RegWrite_m}), 32'({m_mem.mw, m_mem.rs, m_mem.rw}));
    chk("wb_bundle", 32'({ResultSrc_w, RegWrite_w}), 32'({m_wb.rs, m_wb.rw}));
    chk("stall_fd", 32'(stall_fd), 32'(es));
    chk("flush_fd", 32'(flush_fd), 32'(ef));
    chk("illegal_d", 32'(illegal_d), 32'(ill && !rst));
    chk("ImmSrc_d", 32'(ImmSrc_d), rst ? 32'd0 : 32'(imm));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic run_cycle();
    #1;
    if (rst) model_reset();
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic v, input logic [4:0] r1, input logic [4:0] r2);
    opcode = op; func3 = f3; func7 = f7; id_valid = v; rs1_d = r1; rs2_d = r2;
  endtask

  task automatic drain();
    set_id(7'd0, 3'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    rd_e = '0; branch_taken_e = 1'b0; mem_stall = 1'b0;
    repeat (5) run_cycle();
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] alu, input logic src, input logic br, input logic jmp,
                         input logic mw, input logic [1:0] rs, input logic rw,
                         input logic [1:0] imm, input logic ill);
    vec_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.alu = alu; e.src = src; e.br = br; e.jmp = jmp;
    e.mw = mw; e.rs = rs; e.rw = rw; e.imm = imm; e.ill = ill;
    tbl.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] exp_ex;
    model_reset();

    //       op   f3     f7        alu   src   br    jmp   mw    rs     rw    imm    ill
    add_vec(RR,  3'd0, 7'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd0, 7'h20, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd1, 7'h00, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd2, 7'h00, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd3, 7'h00, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd4, 7'h00, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd5, 7'h00, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd5, 7'h20, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd6, 7'h00, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd7, 7'h00, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(IA,  3'd0, 7'h20, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(IA,  3'd5, 7'h20, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(LW,  3'd2, 7'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0);
    add_vec(SW,  3'd2, 7'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0);
    add_vec(BR,  3'd0, 7'h00, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0);
    add_vec(JAL, 3'd0, 7'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0);
    add_vec(RR,  3'd0, 7'h01, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd1, 7'h01, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd4, 7'h01, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(RR,  3'd6, 7'h01, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    add_vec(BAD, 3'd0, 7'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    add_vec(7'b0110111, 3'd0, 7'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    // Reset state, then release.
    @(negedge clk);
    run_cycle();
    chk("reset_ex", 32'(dut_ex()), 32'd0);
    rst = 1'b0;
    drain();

    // Decode table.
    foreach (tbl[i]) begin
      set_id(tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b1, 5'd0, 5'd0);
      #1;
      chk("tbl_imm", 32'(ImmSrc_d), 32'(tbl[i].imm));
      chk("tbl_illegal", 32'(illegal_d), 32'(tbl[i].ill));
      run_cycle();
      exp_ex = tbl[i].ill ? 12'd0 : {tbl[i].alu, tbl[i].src, tbl[i].br, tbl[i].jmp,
                                     tbl[i].mw, tbl[i].rs, tbl[i].rw, 1'b1};
      chk("tbl_ex", 32'(dut_ex()), 32'(exp_ex));
      drain();
    end

    // add x3,x1,x2 then idle: EX after one edge, WB after three.
    set_id(RR, 3'd0, 7'h00, 1'b1, 5'd1, 5'd2);
    run_cycle();
    chk("add_alu_e", 32'(ALUCtl_e), 32'd0);
    chk("add_regwrite_e", 32'(RegWrite_e), 32'd1);
    set_id(7'd0, 3'd0, 7'd0, 1'b0, 5'd0, 5'd0);
    run_cycle();
    run_cycle();
    chk("add_regwrite_w", 32'(RegWrite_w), 32'd1);
    chk("add_resultsrc_w", 32'(ResultSrc_w), 32'd0);
    drain();

    // lw x5 then add x6,x5,x1: one-cycle load-use stall.
    set_id(LW, 3'd2, 7'h00, 1'b1, 5'd1, 5'd0);
    run_cycle();
    set_id(RR, 3'd0, 7'h00, 1'b1, 5'd5, 5'd1);
    rd_e = 5'd5;
    #1 chk("lu_stall", 32'(stall_fd), 32'd1);
    run_cycle();
    chk("lu_bubble", 32'(valid_e), 32'd0);
    chk("lu_lw_in_mem", 32'(ResultSrc_m), 32'd1);
    rd_e = 5'd0;
    #1 chk("lu_release", 32'(stall_fd), 32'd0);
    run_cycle();
    chk("lu_add_late", 32'({valid_e, RegWrite_e, ALUCtl_e}), 32'h30);
    drain();

    // mul: three busy cycles holding EX, bubbles into MEM, then resume.
    set_id(RR, 3'd0, 7'h01, 1'b1, 5'd1, 5'd2);
    run_cycle();
    set_id(RR, 3'd0, 7'h00, 1'b1, 5'd3, 5'd4);
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      #1 chk("mul_stall", 32'(stall_fd), 32'd1);
      run_cycle();
      chk("mul_hold_alu", 32'(ALUCtl_e), 32'd10);
      chk("mul_mem_bubble", 32'(RegWrite_m), 32'd0);
    end
    #1 chk("mul_resume", 32'(stall_fd), 32'd0);
    run_cycle();
    chk("mul_next_in_ex", 32'({valid_e, ALUCtl_e}), 32'h10);
    chk("mul_in_mem", 32'(RegWrite_m), 32'd1);
    drain();

    // Branch redirect coincident with load-use.
    set_id(LW, 3'd2, 7'h00, 1'b1, 5'd1, 5'd0);
    run_cycle();
    set_id(RR, 3'd0, 7'h00, 1'b1, 5'd5, 5'd0);
    rd_e = 5'd5; branch_taken_e = 1'b1;
    #1;
    chk("br_flush", 32'(flush_fd), 32'd1);
    chk("br_no_stall", 32'(stall_fd), 32'd0);
    run_cycle();
    chk("br_bubble", 32'(valid_e), 32'd0);
    drain();

    // Illegal opcode becomes a bubble.
    set_id(BAD, 3'd0, 7'h00, 1'b1, 5'd0, 5'd0);
    #1 chk("illegal_flag", 32'(illegal_d), 32'd1);
    run_cycle();
    chk("illegal_bubble", 32'(dut_ex()), 32'd0);
    drain();

    // Asynchronous reset in the middle of a multi-cycle op.
    set_id(RR, 3'd4, 7'h01, 1'b1, 5'd1, 5'd2);
    run_cycle();
    set_id(SW, 3'd2, 7'h00, 1'b1, 5'd0, 5'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_outputs", 32'({dut_ex(), MemWrite_m, ResultSrc_m, RegWrite_m, ResultSrc_w,
                             RegWrite_w, stall_fd, flush_fd, illegal_d, ImmSrc_d}), 32'd0);
    run_cycle();
    rst = 1'b0;
    run_cycle();
    chk("post_reset_load", 32'({MemWrite_e, valid_e}), 32'd3);
    drain();

    // Two-cycle memory stall mid-stream.
    set_id(RR, 3'd0, 7'h00, 1'b1, 5'd1, 5'd2);
    run_cycle();
    set_id(LW, 3'd2, 7'h00, 1'b1, 5'd1, 5'd0);
    run_cycle();
    set_id(JAL, 3'd0, 7'h00, 1'b1, 5'd0, 5'd0);
    mem_stall = 1'b1;
    repeat (2) begin
      #1 chk("ms_stall", 32'(stall_fd), 32'd1);
      run_cycle();
      chk("ms_ex_frozen", 32'({ResultSrc_e, valid_e}), 32'h3);
      chk("ms_mem_frozen", 32'(RegWrite_m), 32'd1);
    end
    mem_stall = 1'b0;
    run_cycle();
    chk("ms_resume", 32'({Jump_e, ResultSrc_m}), 32'h5);
    drain();

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] op;
      logic [6:0] f7;
      case ($urandom_range(0, 9))
        0: op = LW;  1: op = SW;  2: op = IA;  3: op = BR;  4: op = JAL;
        5, 6, 7: op = RR;  8: op = BAD;  default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;  default: f7 = 7'($urandom);
      endcase
      set_id(op, 3'($urandom), f7, ($urandom_range(0, 9) != 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      rd_e           = 5'($urandom_range(0, 7));
      branch_taken_e = ($urandom_range(0, 9) == 0);
      mem_stall      = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
